// File: rtl/accum_core_mc_if.sv
// Data-memory request/acknowledge bus between the accumulator core (master)
// and a memory that may insert wait states (slave).
interface accum_core_mc_if #(
    parameter int DW = 8
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/accum_core_mc.sv
// Multi-cycle 9-bit-ISA accumulator core: FETCH/EXEC/MEM/HALT sequencer,
// PC-relative branches, req/ack data memory and a retired-instruction counter.
module accum_core_mc #(
    parameter int DW   = 8,
    parameter int D    = 12,
    parameter int NREG = 16,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          start_n,
    output logic [D-1:0]  imem_addr,
    input  logic [8:0]    imem_data,
    accum_core_mc_if.master dmem,
    output logic          done,
    output logic          flag,
    output logic [CW-1:0] retired
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_LSL  = 4'd5,  OP_LSR  = 4'd6,  OP_ADDI = 4'd7;
    localparam logic [3:0] OP_MOVF = 4'd8,  OP_MOVT = 4'd9,  OP_LD   = 4'd10, OP_ST   = 4'd11;
    localparam logic [3:0] OP_BF   = 4'd12, OP_JMP  = 4'd13, OP_CMP  = 4'd14, OP_HALT = 4'd15;

    state_t              state, state_nx;
    logic [D-1:0]        pc;
    logic [8:0]          ir;
    logic [DW-1:0]       regs [16];

    logic [3:0]          op, opr;
    logic [4:0]          imm;
    logic signed [4:0]   imm_s;
    logic signed [D-1:0] simm;
    logic                is_mem, opr_ok, commit;
    logic [DW-1:0]       r0, rr;

    logic                r0_we, rr_we, flag_we, flag_nx;
    logic [DW-1:0]       r0_nx, res;
    logic [DW:0]         sum;
    logic [D-1:0]        pc_nx;

    assign op        = ir[8:5];
    assign opr       = ir[4:1];
    assign imm       = ir[4:0];
    assign imm_s     = signed'(imm);
    assign simm      = D'(imm_s);
    assign is_mem    = (op == OP_LD) || (op == OP_ST);
    // Register indices beyond NREG behave as a hard-wired zero register.
    assign opr_ok    = (int'(opr) < NREG);
    assign r0        = regs[0];
    assign rr        = opr_ok ? regs[opr] : '0;
    assign imem_addr = pc;
    assign commit    = (state == S_EXEC && !is_mem) || (dmem.dmem_req && dmem.dmem_ack);

    always_comb begin
        r0_we   = 1'b0;
        r0_nx   = r0;
        rr_we   = 1'b0;
        flag_we = 1'b0;
        flag_nx = flag;
        sum     = '0;
        res     = '0;
        pc_nx   = pc + D'(1);
        case (op)
            OP_ADD:  begin sum = {1'b0, r0} + {1'b0, rr}; r0_we = 1'b1; r0_nx = sum[DW-1:0];
                           flag_we = 1'b1; flag_nx = sum[DW]; end
            OP_SUB:  begin r0_we = 1'b1; r0_nx = r0 - rr; flag_we = 1'b1; flag_nx = (r0 < rr); end
            OP_AND:  begin res = r0 & rr; r0_we = 1'b1; r0_nx = res; flag_we = 1'b1; flag_nx = (res == '0); end
            OP_OR:   begin res = r0 | rr; r0_we = 1'b1; r0_nx = res; flag_we = 1'b1; flag_nx = (res == '0); end
            OP_XOR:  begin res = r0 ^ rr; r0_we = 1'b1; r0_nx = res; flag_we = 1'b1; flag_nx = (res == '0); end
            OP_LSL:  begin r0_we = 1'b1; r0_nx = r0 << 1; flag_we = 1'b1; flag_nx = r0[DW-1]; end
            OP_LSR:  begin r0_we = 1'b1; r0_nx = r0 >> 1; flag_we = 1'b1; flag_nx = r0[0]; end
            OP_ADDI: begin sum = {1'b0, r0} + (DW+1)'(imm); r0_we = 1'b1; r0_nx = sum[DW-1:0];
                           flag_we = 1'b1; flag_nx = sum[DW]; end
            OP_MOVF: rr_we = opr_ok;
            OP_MOVT: begin r0_we = 1'b1; r0_nx = rr; end
            OP_LD:   begin r0_we = 1'b1; r0_nx = dmem.dmem_rdata; end
            OP_BF:   if (flag) pc_nx = pc + simm;
            OP_JMP:  pc_nx = pc + simm;
            OP_CMP:  begin flag_we = 1'b1; flag_nx = (r0 < rr); end
            OP_HALT: pc_nx = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!start_n) state <= S_FETCH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT)      state_nx = S_HALT;
                else if (!is_mem)       state_nx = S_FETCH;
                else if (dmem.dmem_ack) state_nx = S_FETCH;
                else                    state_nx = S_MEM;
            end
            S_MEM:   if (dmem.dmem_ack) state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

    // Address and data come straight from the register file, which cannot
    // change while an access is outstanding, so they stay stable in MEM.
    always_comb begin
        dmem.dmem_req   = (state == S_EXEC && is_mem) || (state == S_MEM);
        dmem.dmem_we    = (op == OP_ST);
        dmem.dmem_addr  = rr;
        dmem.dmem_wdata = r0;
        done            = (state == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!start_n) begin
            pc      <= '0;
            ir      <= '0;
            flag    <= 1'b0;
            retired <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (state == S_FETCH) ir <= imem_data;
            if (commit) begin
                pc      <= pc_nx;
                retired <= retired + CW'(1);
                if (r0_we)   regs[0]   <= r0_nx;
                if (rr_we)   regs[opr] <= r0;
                if (flag_we) flag      <= flag_nx;
            end
        end
    end
endmodule
